// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: opcodes, opcode classes, FSM states, flag bit positions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wb_pkg;

   // Named opcodes referenced by the decoder; the remaining encodings are grouped by range there.
   localparam logic [4:0] OP_MOV   = 5'h00;
   localparam logic [4:0] OP_MUL   = 5'h03;
   localparam logic [4:0] OP_DIV   = 5'h04;
   localparam logic [4:0] OP_LOAD  = 5'h0B;
   localparam logic [4:0] OP_STORE = 5'h0C;
   localparam logic [4:0] OP_JMP   = 5'h0D;
   localparam logic [4:0] OP_CMP   = 5'h19;
   localparam logic [4:0] OP_HALT  = 5'h1F;

   typedef enum logic [2:0] {
      CLS_REG8,
      CLS_WIDE,
      CLS_STORE,
      CLS_FLOW,
      CLS_CMP,
      CLS_HALT,
      CLS_NONE
   } wb_class_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HIGH,
      ST_HALT
   } wb_state_t;

   // Bit positions inside the 4-bit {parity, ac, carry, zero} flag word.
   localparam int FLG_ZERO   = 0;
   localparam int FLG_CARRY  = 1;
   localparam int FLG_AC     = 2;
   localparam int FLG_PARITY = 3;

endpackage

// File: rtl/wb_op_decode.sv
// Opcode decoder: maps a 5-bit opcode to its commit class and whether it updates the flag register.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: opcode in; op_class, flag_upd out.
module wb_op_decode
   import wb_pkg::*;
(
   input  logic [4:0] opcode,
   output wb_class_t  op_class,
   output logic       flag_upd
);

   always_comb begin
      op_class = CLS_NONE;
      flag_upd = 1'b0;
      case (opcode)
         OP_MOV, 5'h01, 5'h02,
         5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, OP_LOAD,
         5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15: op_class = CLS_REG8;
         OP_MUL, OP_DIV:                           op_class = CLS_WIDE;
         OP_STORE:                                 op_class = CLS_STORE;
         OP_JMP, 5'h0E, 5'h16, 5'h17, 5'h18:       op_class = CLS_FLOW;
         OP_CMP:                                   op_class = CLS_CMP;
         OP_HALT:                                  op_class = CLS_HALT;
         default:                                  op_class = CLS_NONE;
      endcase

      // Move and load copy data without touching flags; every ALU op, MUL/DIV and CMP update them.
      case (opcode)
         5'h01, 5'h02, OP_MUL, OP_DIV, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A,
         5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, OP_CMP: flag_upd = 1'b1;
         default:                                          flag_upd = 1'b0;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: commits executed instructions to the register file, data memory and flag register.
// Latency: 1 cycle accept-to-strobe; MUL/DIV write the high byte one cycle later (2-cycle throughput).
// Backpressure: in_ready drops while a high-byte write is pending and permanently after HALT (until reset).
// Ports: clk/reset (sync, active-high); in_valid/in_ready handshake with opcode, rd, mem_addr, result,
//        flags_in; reg_we/reg_waddr/reg_wdata, mem_we/mem_waddr/mem_wdata, flags_out, halted.
// Build option WB_RETIRE_CNT_EN adds a 16-bit retire_cnt output counting accepted instructions.
module writeback_stage
   import wb_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 3,
   parameter int MEM_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4:0]            opcode,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic [MEM_ADDR_W-1:0] mem_addr,
   input  logic [15:0]           result,
   input  logic [3:0]            flags_in,
   output logic                  reg_we,
   output logic [REG_ADDR_W-1:0] reg_waddr,
   output logic [DATA_W-1:0]     reg_wdata,
   output logic                  mem_we,
   output logic [MEM_ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [3:0]            flags_out,
   output logic                  halted
`ifdef WB_RETIRE_CNT_EN
   ,
   output logic [15:0]           retire_cnt
`endif
);

   wb_state_t             state, state_nxt;
   wb_class_t             op_class;
   logic                  flag_upd;
   logic                  accept;
   // High byte of a MUL/DIV result and its destination, held for the second commit cycle.
   logic [REG_ADDR_W-1:0] hi_addr;
   logic [DATA_W-1:0]     hi_data;

   wb_op_decode u_decode (
      .opcode   (opcode),
      .op_class (op_class),
      .flag_upd (flag_upd)
   );

   assign accept = in_valid && in_ready;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept && op_class == CLS_WIDE)      state_nxt = ST_HIGH;
            else if (accept && op_class == CLS_HALT) state_nxt = ST_HALT;
         end
         ST_HIGH: state_nxt = ST_IDLE;
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decoded from the (registered) state
   always_comb begin
      in_ready = 1'b0;
      halted   = 1'b0;
      case (state)
         ST_IDLE: in_ready = 1'b1;
         ST_HALT: halted   = 1'b1;
         default: ;
      endcase
   end

   // Commit registers. Strobes default low so each write is a single-cycle pulse; address/data
   // hold their last value between writes. Only the low byte of result is ever forwarded for
   // non-WIDE classes, so an undriven high byte cannot reach any output.
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_we    <= 1'b0;
         reg_waddr <= '0;
         reg_wdata <= '0;
         mem_we    <= 1'b0;
         mem_waddr <= '0;
         mem_wdata <= '0;
         flags_out <= '0;
         hi_addr   <= '0;
         hi_data   <= '0;
      end else begin
         reg_we <= 1'b0;
         mem_we <= 1'b0;
         if (state == ST_HIGH) begin
            reg_we    <= 1'b1;
            reg_waddr <= hi_addr;
            reg_wdata <= hi_data;
         end else if (accept) begin
            case (op_class)
               CLS_REG8, CLS_WIDE: begin
                  reg_we    <= 1'b1;
                  reg_waddr <= rd;
                  reg_wdata <= result[DATA_W-1:0];
               end
               CLS_STORE: begin
                  mem_we    <= 1'b1;
                  mem_waddr <= mem_addr;
                  mem_wdata <= result[DATA_W-1:0];
               end
               default: ;
            endcase
            if (op_class == CLS_WIDE) begin
               hi_addr <= rd + REG_ADDR_W'(1);   // wraps r7 -> r0
               hi_data <= result[2*DATA_W-1:DATA_W];
            end
         end
         if (accept && flag_upd) flags_out <= flags_in;
      end
   end

`ifdef WB_RETIRE_CNT_EN
   // Counted at acceptance, so a MUL/DIV retires once despite its two writes.
   always_ff @(posedge clk) begin
      if (reset)       retire_cnt <= '0;
      else if (accept) retire_cnt <= retire_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: scoreboard of expected register/memory writes plus
// directed checks on reset values, flags, handshake timing, HALT and reset during a pending high byte.
// Backpressure: the driver waits (bounded) on in_ready before each transfer.
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  opcode;
   logic [2:0]  rd;
   logic [3:0]  mem_addr;
   logic [15:0] result;
   logic [3:0]  flags_in;
   logic        reg_we;
   logic [2:0]  reg_waddr;
   logic [7:0]  reg_wdata;
   logic        mem_we;
   logic [3:0]  mem_waddr;
   logic [7:0]  mem_wdata;
   logic [3:0]  flags_out;
   logic        halted;
`ifdef WB_RETIRE_CNT_EN
   logic [15:0] retire_cnt;
`endif

   writeback_stage dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .rd        (rd),
      .mem_addr  (mem_addr),
      .result    (result),
      .flags_in  (flags_in),
      .reg_we    (reg_we),
      .reg_waddr (reg_waddr),
      .reg_wdata (reg_wdata),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .flags_out (flags_out),
      .halted    (halted)
`ifdef WB_RETIRE_CNT_EN
      ,
      .retire_cnt(retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_mem;
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t         sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [3:0]  exp_flags = 4'h0;
   logic [15:0] exp_retire = 16'h0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference classification, written from the opcode table.
   function automatic bit is_reg8(input logic [4:0] op);
      return (op <= 5'd2) || (op >= 5'd5 && op <= 5'd11) || (op >= 5'd16 && op <= 5'd21);
   endfunction
   function automatic bit is_wide(input logic [4:0] op);
      return op == 5'd3 || op == 5'd4;
   endfunction
   function automatic bit upd_flags(input logic [4:0] op);
      return (op >= 5'd1 && op <= 5'd10) || (op >= 5'd16 && op <= 5'd21) || op == 5'd25;
   endfunction

   // Monitor: every strobe must match the oldest pending expected write.
   always @(negedge clk) begin
      if (reg_we && mem_we) check("both_we", 1, 0);
      if (reg_we || mem_we) begin
         if (sb.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_kind", {31'd0, mem_we}, {31'd0, e.is_mem});
            if (mem_we) begin
               check("mem_waddr", {28'd0, mem_waddr}, {28'd0, e.addr});
               check("mem_wdata", {24'd0, mem_wdata}, {24'd0, e.data});
            end else begin
               check("reg_waddr", {29'd0, reg_waddr}, {28'd0, e.addr});
               check("reg_wdata", {24'd0, reg_wdata}, {24'd0, e.data});
            end
         end
      end
   end

   task automatic drive(input logic [4:0] op, input logic [2:0] r, input logic [3:0] ma,
                        input logic [15:0] res, input logic [3:0] fl);
      in_valid = 1'b1;
      opcode   = op;
      rd       = r;
      mem_addr = ma;
      result   = res;
      flags_in = fl;
   endtask

   // One transfer: wait for in_ready (bounded), record expected writes, take the accepting edge.
   // in_valid stays high so consecutive calls are back-to-back.
   task automatic send(input logic [4:0] op, input logic [2:0] r, input logic [3:0] ma,
                       input logic [15:0] res, input logic [3:0] fl);
      int   w = 0;
      wr_t  e;
      drive(op, r, ma, res, fl);
      while (!in_ready && w < 10) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready) begin
         check("ready_timeout", 0, 1);
         return;
      end
      if (is_reg8(op) || is_wide(op)) begin
         e.is_mem = 1'b0; e.addr = {1'b0, r}; e.data = res[7:0];
         sb.push_back(e);
      end
      if (is_wide(op)) begin
         e.is_mem = 1'b0; e.addr = {1'b0, r + 3'd1}; e.data = res[15:8];
         sb.push_back(e);
      end
      if (op == 5'd12) begin
         e.is_mem = 1'b1; e.addr = ma; e.data = res[7:0];
         sb.push_back(e);
      end
      @(posedge clk); #1;
      if (upd_flags(op)) exp_flags = fl;
      exp_retire = exp_retire + 16'd1;
      check("flags_out", {28'd0, flags_out}, {28'd0, exp_flags});
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_reg_we"},    {31'd0, reg_we},    0);
      check({tag, "_mem_we"},    {31'd0, mem_we},    0);
      check({tag, "_reg_waddr"}, {29'd0, reg_waddr}, 0);
      check({tag, "_reg_wdata"}, {24'd0, reg_wdata}, 0);
      check({tag, "_mem_waddr"}, {28'd0, mem_waddr}, 0);
      check({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 0);
      check({tag, "_flags"},     {28'd0, flags_out}, 0);
      check({tag, "_halted"},    {31'd0, halted},    0);
      check({tag, "_in_ready"},  {31'd0, in_ready},  1);
   endtask

   initial begin
      reset = 1'b1;
      drive(5'd0, 3'd0, 4'd0, 16'h0, 4'h0);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("rst");
      reset = 1'b0;

      // ADD with undriven high byte
      send(5'd1, 3'd3, 4'd0, {8'hxx, 8'h5A}, 4'b0011);
      check("add_reg_we", {31'd0, reg_we}, 1);
      check("add_no_x", {31'd0, $isunknown({reg_waddr, reg_wdata, mem_waddr, mem_wdata, flags_out})}, 0);
      idle(1);

      // MUL into r7: high byte wraps to r0, in_ready low during A+1
      send(5'd3, 3'd7, 4'd0, 16'h12C8, 4'b0100);
      check("mul_ready_a1", {31'd0, in_ready}, 0);
      check("mul_lo_we", {31'd0, reg_we}, 1);
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("mul_hi_we", {31'd0, reg_we}, 1);
      check("mul_hi_addr", {29'd0, reg_waddr}, 0);
      check("mul_ready_a2", {31'd0, in_ready}, 1);
      idle(1);

      // STORE leaves flags alone
      send(5'd12, 3'd1, 4'hE, {8'hxx, 8'h3C}, 4'hF);
      check("st_reg_we", {31'd0, reg_we}, 0);
      idle(1);

      // Jump then CMP: no strobes, flags only after CMP
      send(5'd13, 3'd2, 4'd0, 16'h00FF, 4'b1111);
      send(5'd25, 3'd2, 4'd0, 16'h0000, 4'b0001);
      idle(2);

      // Back-to-back REG8/STORE stream: no wait states allowed
      for (int i = 0; i < 12; i++) begin
         logic [4:0] op;
         op = (i % 3 == 2) ? 5'd12 : 5'(16 + (i % 6));
         send(op, 3'($urandom), 4'($urandom), {8'hxx, 8'($urandom)}, 4'($urandom));
         check("b2b_ready", {31'd0, in_ready}, 1);
      end
      idle(1);

      // Random mix over every non-HALT opcode
      for (int i = 0; i < 40; i++) begin
         logic [4:0] op;
         logic [15:0] res;
         op  = 5'($urandom_range(0, 30));
         res = 16'($urandom);
         if (!is_wide(op)) res[15:8] = 8'hxx;
         send(op, 3'($urandom), 4'($urandom), res, 4'($urandom));
         if ((i % 5) == 4) idle(1);
      end
      idle(3);
      check("sb_drain_mid", sb.size(), 0);

      // HALT, then keep presenting an ADD
      send(5'd31, 3'd0, 4'd0, 16'h0, 4'hA);
      check("halt_halted", {31'd0, halted}, 1);
      check("halt_ready", {31'd0, in_ready}, 0);
      drive(5'd1, 3'd4, 4'd0, 16'h0077, 4'h5);
      repeat (5) begin @(posedge clk); #1; end
      check("halt_still", {31'd0, halted}, 1);
      check("halt_ready_still", {31'd0, in_ready}, 0);
      check("halt_flags_held", {28'd0, flags_out}, {28'd0, exp_flags});

`ifdef WB_RETIRE_CNT_EN
      check("retire_cnt", {16'd0, retire_cnt}, {16'd0, exp_retire});
`endif

      // Reset wins over a simultaneous accept (in_valid still high with ADD)
      reset = 1'b1;
      @(posedge clk); #1;
      check_reset_vals("rst2");
      drive(5'd1, 3'd4, 4'd0, 16'h0077, 4'h5);
      @(posedge clk); #1;
      check("rst_prio_we", {31'd0, reg_we}, 0);
      check("rst_prio_flags", {28'd0, flags_out}, 0);
      reset = 1'b0;
      in_valid = 1'b0;
      exp_flags = 4'h0;
      exp_retire = 16'h0;
      @(posedge clk); #1;

      // DIV with reset in the HIGH cycle: only the low byte is written
      begin
         wr_t e;
         e.is_mem = 1'b0; e.addr = 4'd2; e.data = 8'hCD;
         sb.push_back(e);
      end
      drive(5'd4, 3'd2, 4'd0, 16'hABCD, 4'b1010);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("div_lo_we", {31'd0, reg_we}, 1);
      check("div_ready_a1", {31'd0, in_ready}, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_reset_vals("rst_div");
      @(posedge clk); #1;
      check("div_no_hi", {31'd0, reg_we}, 0);
`ifdef WB_RETIRE_CNT_EN
      check("retire_after_rst", {16'd0, retire_cnt}, 0);
`endif
      idle(2);
      check("sb_drain_end", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
